// File: rtl/sd_host_pkg.sv
// Shared SD host constants: timer state encoding, timer channel roles
// and protocol delay values used by the command/data engines.
package sd_host_pkg;

  localparam logic [0:0] TMR_IDLE = 1'b0;
  localparam logic [0:0] TMR_RUN  = 1'b1;

  // Fixed channel assignment inside the host controller
  localparam int TMR_INIT    = 0;
  localparam int TMR_NCR     = 1;
  localparam int TMR_DATA    = 2;
  localparam int TMR_CLKTICK = 3;

  localparam int INIT_CLOCKS = 74;
  localparam int NCR_MAX     = 64;

endpackage

// File: rtl/sd_timer_channel.sv
// One programmable down-counter channel: prescaled ticks, one-shot or
// periodic reload, one-cycle terminal pulse and sticky expired flag.
module sd_timer_channel
  import sd_host_pkg::*;
#(
  parameter int COUNT_BITS    = 16,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [PRESCALE_BITS-1:0] prescale,
  input  logic [COUNT_BITS-1:0]    load_value,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     periodic,
  input  logic                     clear_expired,
  output logic                     busy,
  output logic                     pulse,
  output logic                     expired,
  output logic [COUNT_BITS-1:0]    count
);

  logic [0:0]               state_reg, state_next;
  logic [COUNT_BITS-1:0]    count_reg, count_next;
  logic [PRESCALE_BITS-1:0] pre_reg, pre_next;
  logic                     pulse_reg, pulse_next;
  logic                     expired_reg, expired_next;
  logic                     terminal;

  // Priority: stop, then start (which also masks a coincident terminal),
  // then terminal/tick handling while running.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    pre_next   = pre_reg;
    pulse_next = 1'b0;
    terminal   = 1'b0;
    if (stop) begin
      state_next = TMR_IDLE;
      count_next = '0;
      pre_next   = '0;
    end else if (start) begin
      state_next = TMR_RUN;
      count_next = load_value;
      pre_next   = prescale;
    end else if (state_reg == TMR_RUN) begin
      if (pre_reg != '0) begin
        pre_next = pre_reg - PRESCALE_BITS'(1);
      end else begin
        pre_next = prescale;
        if (count_reg != '0) begin
          count_next = count_reg - COUNT_BITS'(1);
        end else begin
          terminal   = 1'b1;
          pulse_next = 1'b1;
          if (periodic) count_next = load_value;
          else          state_next = TMR_IDLE;
        end
      end
    end
    expired_next = terminal ? 1'b1 : (clear_expired ? 1'b0 : expired_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= TMR_IDLE;
      count_reg   <= '0;
      pre_reg     <= '0;
      pulse_reg   <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      pre_reg     <= pre_next;
      pulse_reg   <= pulse_next;
      expired_reg <= expired_next;
    end
  end

  assign busy    = (state_reg == TMR_RUN);
  assign pulse   = pulse_reg;
  assign expired = expired_reg;
  assign count   = count_reg;

endmodule

// File: rtl/sd_timer.sv
// Multi-channel timer: a bank of independent sd_timer_channel instances
// sharing one prescale value, with per-channel packed buses.
module sd_timer
  import sd_host_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int COUNT_BITS    = 16,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [PRESCALE_BITS-1:0]       prescale,
  input  logic [CHANNELS*COUNT_BITS-1:0] load_value,
  input  logic [CHANNELS-1:0]            start,
  input  logic [CHANNELS-1:0]            stop,
  input  logic [CHANNELS-1:0]            periodic,
  input  logic [CHANNELS-1:0]            clear_expired,
  output logic [CHANNELS-1:0]            busy,
  output logic [CHANNELS-1:0]            pulse,
  output logic [CHANNELS-1:0]            expired,
  output logic [CHANNELS*COUNT_BITS-1:0] count
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      sd_timer_channel #(
        .COUNT_BITS    (COUNT_BITS),
        .PRESCALE_BITS (PRESCALE_BITS)
      ) u_chan (
        .clk           (clk),
        .reset_n       (reset_n),
        .prescale      (prescale),
        .load_value    (load_value[gi*COUNT_BITS +: COUNT_BITS]),
        .start         (start[gi]),
        .stop          (stop[gi]),
        .periodic      (periodic[gi]),
        .clear_expired (clear_expired[gi]),
        .busy          (busy[gi]),
        .pulse         (pulse[gi]),
        .expired       (expired[gi]),
        .count         (count[gi*COUNT_BITS +: COUNT_BITS])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sd_timer.sv
// Directed bench for sd_timer: reset, one-shot, periodic, restart/stop,
// set-vs-clear of expired and channel independence.
module tb_sd_timer;

  localparam int CH = 4;
  localparam int CB = 16;
  localparam int PB = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [PB-1:0]     prescale;
  logic [CH*CB-1:0]  load_value;
  logic [CH-1:0]     start, stop, periodic, clear_expired;
  logic [CH-1:0]     busy, pulse, expired;
  logic [CH*CB-1:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sd_timer #(.CHANNELS(CH), .COUNT_BITS(CB), .PRESCALE_BITS(PB)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .prescale      (prescale),
    .load_value    (load_value),
    .start         (start),
    .stop          (stop),
    .periodic      (periodic),
    .clear_expired (clear_expired),
    .busy          (busy),
    .pulse         (pulse),
    .expired       (expired),
    .count         (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: got %0d", tag, obs);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_load(input int ch, input int val);
    load_value[ch*CB +: CB] = CB'(val);
  endtask

  function automatic logic [CB-1:0] cnt(input int ch);
    return count[ch*CB +: CB];
  endfunction

  task automatic kick(input logic [CH-1:0] mask);
    start = mask;
    step(1);
    start = '0;
  endtask

  int first_p [CH];
  int n_p [CH];
  int p1, p2, np;
  logic b73, b74;
  int cnt_exp [6] = '{4, 3, 2, 1, 0, 4};
  int edge_exp [CH] = '{2, 12, 22, 42};

  initial begin
    reset_n = 1'b0;
    prescale = '0;
    load_value = '0;
    start = '0;
    stop = '0;
    periodic = '0;
    clear_expired = '0;

    // Reset state
    step(2);
    check("rst_busy", busy, 0);
    check("rst_pulse", pulse, 0);
    check("rst_expired", expired, 0);
    check("rst_count", count[31:0], 0);
    reset_n = 1'b1;
    step(1);

    // Reset mid-count: L=100, P=3 on ch0
    prescale = 8'd3;
    set_load(0, 100);
    kick(4'b0001);
    step(20);
    check("mid_count_ch0", cnt(0), 95);
    check("mid_busy_ch0", busy[0], 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_count", cnt(0), 0);
    check("async_pulse_exp", {pulse, expired}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    np = 0;
    for (int m = 1; m <= 450; m++) begin
      step(1);
      if (pulse[0]) np++;
    end
    check("post_rst_no_pulse", np, 0);
    check("post_rst_expired", expired[0], 0);

    // One-shot: P=0, L=73 on ch0, pulse after edge k+74
    prescale = 8'd0;
    set_load(0, 73);
    kick(4'b0001);
    check("os_busy_start", busy[0], 1);
    check("os_count_start", cnt(0), 73);
    np = 0; p1 = 0; b73 = 1'b0; b74 = 1'b1;
    for (int m = 1; m <= 80; m++) begin
      step(1);
      if (pulse[0]) begin np++; if (p1 == 0) p1 = m; end
      if (m == 73) b73 = busy[0];
      if (m == 74) b74 = busy[0];
    end
    check("os_pulse_edge", p1, 74);
    check("os_pulse_count", np, 1);
    check("os_busy_73", b73, 1);
    check("os_busy_74", b74, 0);
    step(5);
    check("os_expired_sticky", expired[0], 1);
    clear_expired = 4'b0001;
    step(1);
    clear_expired = '0;
    check("os_expired_clear", expired[0], 0);

    // L=0, P=0 periodic: pulse high every cycle while running
    set_load(0, 0);
    periodic = 4'b0001;
    kick(4'b0001);
    np = 0;
    for (int m = 1; m <= 4; m++) begin
      step(1);
      if (pulse[0]) np++;
    end
    check("cont_pulse", np, 4);
    stop = 4'b0001;
    periodic = '0;
    step(1);
    stop = '0;
    check("cont_stop_busy", busy[0], 0);

    // Prescaled periodic: P=2, L=4 on ch1, period 15
    prescale = 8'd2;
    set_load(1, 4);
    periodic = 4'b0010;
    kick(4'b0010);
    check("per_count_m0", cnt(1), 4);
    np = 0; p1 = 0; p2 = 0;
    for (int m = 1; m <= 31; m++) begin
      step(1);
      if (pulse[1]) begin
        np++;
        if (p1 == 0) p1 = m; else if (p2 == 0) p2 = m;
      end
      if (m % 3 == 0 && m <= 15) check($sformatf("per_count_m%0d", m), cnt(1), cnt_exp[m/3]);
    end
    check("per_pulse1", p1, 15);
    check("per_pulse2", p2, 30);
    check("per_npulse", np, 2);
    check("per_busy", busy[1], 1);
    stop = 4'b0010;
    periodic = '0;
    step(1);
    stop = '0;
    check("per_stop_busy", busy[1], 0);
    check("per_stop_count", cnt(1), 0);

    // Restart on ch2 exactly at the terminal edge: P=1, L=3 (interval 8)
    prescale = 8'd1;
    set_load(2, 3);
    kick(4'b0100);
    step(7);
    kick(4'b0100);
    check("rs_pulse_suppr", pulse[2], 0);
    check("rs_expired_suppr", expired[2], 0);
    check("rs_count_reload", cnt(2), 3);
    check("rs_busy", busy[2], 1);
    np = 0; p1 = 0;
    for (int m = 1; m <= 10; m++) begin
      step(1);
      if (pulse[2]) begin np++; if (p1 == 0) p1 = m; end
    end
    check("rs_next_pulse", p1, 8);
    check("rs_npulse", np, 1);
    kick(4'b0100);
    step(2);
    stop = 4'b0100;
    start = 4'b0100;
    step(1);
    stop = '0;
    start = '0;
    check("ss_busy", busy[2], 0);
    check("ss_count", cnt(2), 0);

    // clear_expired coincident with terminal on ch3: set wins
    prescale = 8'd0;
    set_load(3, 2);
    kick(4'b1000);
    step(2);
    clear_expired = 4'b1000;
    step(1);
    clear_expired = '0;
    check("sc_pulse", pulse[3], 1);
    check("sc_expired", expired[3], 1);
    check("sc_busy", busy[3], 0);

    // Channel independence: L=0,5,10,20 with P=1
    clear_expired = 4'hF;
    step(1);
    clear_expired = '0;
    check("ind_expired_clr", expired, 0);
    prescale = 8'd1;
    set_load(0, 0);
    set_load(1, 5);
    set_load(2, 10);
    set_load(3, 20);
    for (int c = 0; c < CH; c++) begin first_p[c] = 0; n_p[c] = 0; end
    kick(4'hF);
    check("ind_busy_all", busy, 4'hF);
    for (int m = 1; m <= 45; m++) begin
      step(1);
      for (int c = 0; c < CH; c++) begin
        if (pulse[c]) begin
          n_p[c]++;
          if (first_p[c] == 0) first_p[c] = m;
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      check($sformatf("ind_edge_ch%0d", c), first_p[c], edge_exp[c]);
      check($sformatf("ind_npulse_ch%0d", c), n_p[c], 1);
    end
    check("ind_busy_done", busy, 0);
    check("ind_expired_all", expired, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
